apu_int_div_resp: RTL and testbench

APU_INT_DIV_RESP -- requirements
Module: apu_int_div_resp

---
 rtl/apu_int_div_resp.sv | 178 +++++++++++++++++
 tb/tb_apu_int_div_resp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/apu_int_div_resp.sv
// Shared-unit integer divider responder.
// Restoring radix-2 divider for DIVU/DIV/REMU/REM behind an APU-style
// request/grant/rvalid handshake. Divide-by-zero and signed overflow are
// resolved at grant time and skip the iterative phase.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready; apu_gnt_o high, operands latched on req && gnt
// CALC  | one restoring shift-subtract step per cycle, 32 steps total
// FIN   | sign-corrected result presented with a one-cycle rvalid strobe
module apu_int_div_resp #(
  parameter int NARGS    = 3,
  parameter int WOP      = 6,
  parameter int NUSFLAGS = 5,
  parameter int NDSFLAGS = 15
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        apu_req_i,
  output logic                        apu_gnt_o,
  input  logic [NARGS-1:0][31:0]      apu_operands_i,
  input  logic [WOP-1:0]              apu_op_i,
  input  logic [NDSFLAGS-1:0]         apu_flags_i,
  output logic                        apu_rvalid_o,
  output logic [31:0]                 apu_result_o,
  output logic [NUSFLAGS-1:0]         apu_flags_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [31:0]         quo_q, quo_d;     // dividend shifts out, quotient shifts in
  logic [31:0]         rem_q, rem_d;
  logic [31:0]         dvs_q, dvs_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic                dz_q, dz_d;
  logic [31:0]         result_q, result_d;
  logic [NUSFLAGS-1:0] flags_q, flags_d;

  // Operand views used at grant time.
  logic [31:0]         dvd_raw, dvs_raw, dvd_abs, dvs_abs;
  logic                is_signed, dvd_neg, dvs_neg, div_zero, ovf, grant;
  // One restoring step: 33-bit partial remainder.
  logic [32:0]         shifted, diff;
  // Sign-corrected result presented in FIN.
  logic [31:0]         fin_quo, fin_rem, fin_res;
  logic [NUSFLAGS-1:0] fin_flags;

  // Operand slots, opcode bits and downstream flags that carry no meaning here.
  logic                unused_inputs;
  assign unused_inputs = ^{apu_operands_i[NARGS-1:2], apu_op_i[WOP-1:2], apu_flags_i};

  assign apu_gnt_o    = (state_q == IDLE);
  assign apu_rvalid_o = (state_q == FIN);
  assign grant        = apu_req_i & apu_gnt_o;

  // Result/flags are live during FIN and otherwise hold the last delivered value.
  assign apu_result_o = (state_q == FIN) ? fin_res   : result_q;
  assign apu_flags_o  = (state_q == FIN) ? fin_flags : flags_q;

  // Operand decode and special-case detection for the grant cycle.
  always_comb begin
    dvd_raw   = apu_operands_i[0];
    dvs_raw   = apu_operands_i[1];
    is_signed = apu_op_i[0];
    dvd_neg   = is_signed & dvd_raw[31];
    dvs_neg   = is_signed & dvs_raw[31];
    dvd_abs   = dvd_neg ? (32'd0 - dvd_raw) : dvd_raw;
    dvs_abs   = dvs_neg ? (32'd0 - dvs_raw) : dvs_raw;
    div_zero  = (dvs_raw == 32'd0);
    ovf       = is_signed & (dvd_raw == 32'h8000_0000) & (dvs_raw == 32'hFFFF_FFFF);
  end

  // Restoring step datapath and FIN sign correction.
  always_comb begin
    shifted   = {rem_q, quo_q[31]};
    diff      = shifted - {1'b0, dvs_q};
    fin_quo   = q_neg_q ? (32'd0 - quo_q) : quo_q;
    fin_rem   = r_neg_q ? (32'd0 - rem_q) : rem_q;
    fin_res   = op_q[1] ? fin_rem : fin_quo;
    fin_flags = '0;
    fin_flags[3] = dz_q;
  end

  // Next-state and datapath update for the divider FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dz_d     = dz_q;
    result_d = result_q;
    flags_d  = flags_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          op_d    = apu_op_i[1:0];
          dvs_d   = dvs_abs;
          dz_d    = div_zero;
          if (div_zero || ovf) begin
            // Preload the final values; sign flags cleared so FIN passes them through.
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            quo_d   = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
            rem_d   = div_zero ? dvd_raw : 32'd0;
            cnt_d   = 5'd0;
            state_d = FIN;
          end else begin
            q_neg_d = dvd_neg ^ dvs_neg;
            r_neg_d = dvd_neg;
            quo_d   = dvd_abs;
            rem_d   = 32'd0;
            cnt_d   = 5'd31;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = FIN;
      end
      FIN: begin
        result_d = fin_res;
        flags_d  = fin_flags;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_apu_int_div_resp.sv
// Self-checking bench for apu_int_div_resp: scoreboard of expected results
// (value, flags, due cycle) pushed on grant and popped on rvalid.
module tb_apu_int_div_resp;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req;
  logic             gnt;
  logic [2:0][31:0] operands;
  logic [5:0]       op;
  logic [14:0]      dflags;
  logic             rvalid;
  logic [31:0]      result;
  logic [4:0]       uflags;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic prev_rv = 1'b0;

  apu_int_div_resp dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .apu_req_i      (req),
    .apu_gnt_o      (gnt),
    .apu_operands_i (operands),
    .apu_op_i       (op),
    .apu_flags_i    (dflags),
    .apu_rvalid_o   (rvalid),
    .apu_result_o   (result),
    .apu_flags_o    (uflags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference behaviour of the divider, written from the operation definitions.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [4:0] flg, output int lat);
    logic signed [31:0] sa, sb_;
    sa  = a;
    sb_ = b;
    flg = 5'h00;
    lat = 33;
    if (b == 32'd0) begin
      lat = 1;
      flg = 5'h08;
      res = o[1] ? a : 32'hFFFF_FFFF;
    end else if (o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lat = 1;
      res = o[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      case (o)
        2'b00:   res = a / b;
        2'b01:   res = sa / sb_;
        2'b10:   res = a % b;
        default: res = sa % sb_;
      endcase
    end
  endtask

  task automatic push_exp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   lat;
    model(o, a, b, e.res, e.flg, lat);
    e.due = cyc + lat;
    sb.push_back(e);
  endtask

  // Monitor: every rvalid must match the oldest expectation, on its due cycle.
  always @(negedge clk) begin
    if (rvalid) begin
      chk("rvalid_one_cycle", {31'd0, prev_rv}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("flags", {27'd0, uflags}, {27'd0, e.flg});
        chk("latency", cyc, e.due);
      end
    end
    prev_rv <= rvalid;
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("rvalid_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // One request, held for a single cycle, then wait for its response.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    req         = 1'b1;
    op          = {4'b1010, o};
    operands[0] = a;
    operands[1] = b;
    operands[2] = $urandom;
    dflags      = 15'($urandom);
    @(negedge clk);
    chk("gnt_idle", {31'd0, gnt}, 32'd1);
    push_exp(o, a, b);
    @(posedge clk);
    #1;
    req = 1'b0;
    operands = '0;
    drain();
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 1'b0;
    operands = '0;
    op       = '0;
    dflags   = '0;
    @(negedge clk);
    chk("rst_gnt", {31'd0, gnt}, 32'd1);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {27'd0, uflags}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(2'b00, 32'd100, 32'd7);
    chk("hold_after_fin", result, 32'd14);
    do_op(2'b10, 32'd100, 32'd7);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2);
    do_op(2'b01, 32'hFFFF_FFF9, 32'd2);
    do_op(2'b01, 32'd5, 32'd0);
    chk("hold_dz_flag", {27'd0, uflags}, 32'h08);
    do_op(2'b10, 32'd5, 32'd0);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd0);
    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(2'b01, 32'h8000_0000, 32'd1);
    do_op(2'b00, 32'hFFFF_FFFF, 32'd1);
    do_op(2'b01, 32'd7, 32'hFFFF_FFFE);

    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i == 3) b = 32'd0 - 32'd13;
      do_op(2'($urandom_range(0, 3)), a, b);
    end

    // Held request: busy window must refuse grants until the cycle after FIN.
    req         = 1'b1;
    op          = 6'b000000;
    operands[0] = 32'd1000;
    operands[1] = 32'd3;
    @(negedge clk);
    chk("held_gnt_c0", {31'd0, gnt}, 32'd1);
    push_exp(2'b00, 32'd1000, 32'd3);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      chk("held_gnt_busy", {31'd0, gnt}, 32'd0);
    end
    @(negedge clk);
    chk("held_gnt_c34", {31'd0, gnt}, 32'd1);
    push_exp(2'b00, 32'd1000, 32'd3);
    @(posedge clk);
    #1;
    req = 1'b0;
    drain();

    // Reset in the middle of CALC: the operation vanishes.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req         = 1'b1;
    op          = 6'b000000;
    operands[0] = 32'd100;
    operands[1] = 32'd7;
    @(negedge clk);
    chk("abort_gnt", {31'd0, gnt}, 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, gnt}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_rvalid", {31'd0, rvalid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_gnt_after", {31'd0, gnt}, 32'd1);
    chk("abort_result", result, 32'd0);
    chk("abort_flags", {27'd0, uflags}, 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_gnt_end", {31'd0, gnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
